// File: rtl/bound_flasher_pkg.sv
// Shared types and default geometry for the bound flasher.
package bound_flasher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UP1,
    ST_DN1,
    ST_UP2,
    ST_DN2,
    ST_UP3,
    ST_DN3
  } state_t;

  localparam int DEF_N        = 16;
  localparam int DEF_B1       = 5;
  localparam int DEF_B2       = 10;
  localparam int DEF_STEP_DIV = 1;

endpackage

// File: rtl/bf_tick_gen.sv
// Step prescaler: counts 0..STEP_DIV-1 and emits a tick on the last count.
module bf_tick_gen #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !hold;

endmodule

// File: rtl/bound_flasher_param.sv
// Bounded LED flasher: three fill/drain passes with flk-driven kickbacks.
// state | meaning
// IDLE  | waiting for flk
// UP1   | fill 0 -> B1
// DN1   | drain -> 0
// UP2   | fill -> B2 (flk at B1/B2 kicks back to DN1)
// DN2   | drain -> B1
// UP3   | fill -> N (flk at B2 kicks back to DN2)
// DN3   | drain -> 0, then done
module bound_flasher_param
  import bound_flasher_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int B1       = DEF_B1,
  parameter int B2       = DEF_B2,
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flk,
  input  logic                   hold,
  input  logic                   mirror,
  output logic [N-1:0]           led,
  output logic [$clog2(N+1)-1:0] level,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = $clog2(N + 1);
  localparam logic [LW-1:0] L_B1 = LW'(B1);
  localparam logic [LW-1:0] L_B2 = LW'(B2);
  localparam logic [LW-1:0] L_N  = LW'(N);
  localparam logic [N-1:0]  ONES = '1;

  state_t        state, state_nxt;
  logic [LW-1:0] level_nxt;
  logic [LW-1:0] lvl_up, lvl_dn;
  logic          done_nxt;
  logic          tick;
  logic          clr;

  // Prescaler is held cleared while idle so every sequence starts on a fresh count.
  assign clr = (state == ST_IDLE);

  bf_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .hold (hold),
    .tick (tick)
  );

  assign lvl_up = (level == L_N) ? level : level + LW'(1);
  assign lvl_dn = (level == '0)  ? level : level - LW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      level <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (flk && !hold) begin
          state_nxt = ST_UP1;
          level_nxt = '0;
        end
      end
      ST_UP1: begin
        if (tick) begin
          level_nxt = lvl_up;
          if (lvl_up == L_B1) state_nxt = ST_DN1;
        end
      end
      ST_DN1: begin
        if (tick) begin
          level_nxt = lvl_dn;
          if (lvl_dn == '0) state_nxt = ST_UP2;
        end
      end
      ST_UP2: begin
        if (tick) begin
          level_nxt = lvl_up;
          if (flk && (lvl_up == L_B1 || lvl_up == L_B2)) state_nxt = ST_DN1;
          else if (lvl_up == L_B2)                       state_nxt = ST_DN2;
        end
      end
      ST_DN2: begin
        if (tick) begin
          level_nxt = lvl_dn;
          if (lvl_dn == L_B1) state_nxt = ST_UP3;
        end
      end
      ST_UP3: begin
        if (tick) begin
          level_nxt = lvl_up;
          if (flk && lvl_up == L_B2) state_nxt = ST_DN2;
          else if (lvl_up == L_N)    state_nxt = ST_DN3;
        end
      end
      ST_DN3: begin
        if (tick) begin
          level_nxt = lvl_dn;
          if (lvl_dn == '0) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Thermometer code: shifting all-ones by level leaves exactly level bits lit.
  always_comb begin
    busy = (state != ST_IDLE);
    led  = mirror ? ~(ONES >> level) : ~(ONES << level);
  end

endmodule
